// File: rtl/cmp_share_arbiter_if.sv
// Bundle of requester-side and comparator-side signals for the shared
// 3-bit comparator arbiter. The arbiter uses the slave modport; whoever
// supplies requests, operands and the comparator outputs uses master.
interface cmp_share_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] a_in;
    logic [3*NREQ-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [2:0]        res;
    logic              res_err;
    logic [2:0]        cmp_X;
    logic [2:0]        cmp_Y;
    logic              cmp_xgty;
    logic              cmp_xlty;
    logic              cmp_xeqy;

    modport slave (
        input  req, a_in, b_in, cmp_xgty, cmp_xlty, cmp_xeqy,
        output gnt, done, res, res_err, cmp_X, cmp_Y
    );

    modport master (
        output req, a_in, b_in, cmp_xgty, cmp_xlty, cmp_xeqy,
        input  gnt, done, res, res_err, cmp_X, cmp_Y
    );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one external 3-bit magnitude
// comparator among NREQ requesters. Operands of the winner are latched onto
// the comparator, held for SETTLE cycles, then the {gt,lt,eq} result is
// sampled, checked for one-hotness and returned with a one-cycle done pulse.
module cmp_share_arbiter #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 2
) (
    input logic             clk,
    input logic             rst,
    cmp_share_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [2:0]        res_q, res_d;
    logic              err_q, err_d;
    logic [2:0]        x_q, x_d;
    logic [2:0]        y_q, y_d;

    logic              found;
    logic [PW-1:0]     win;
    logic [2:0]        sample;

    // A valid comparator answer has exactly one of gt/lt/eq set.
    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    assign sample = {bus.cmp_xgty, bus.cmp_xlty, bus.cmp_xeqy};

    // Round-robin search starting just after the last winner, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // Next-state and next-output computation for the grant/settle/done sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        res_d   = res_q;
        err_d   = err_q;
        x_d     = x_q;
        y_d     = y_q;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    gnt_d = '0;
                    for (int j = 0; j < NREQ; j++) begin
                        if (PW'(j) == win) begin
                            x_d      = bus.a_in[3*j +: 3];
                            y_d      = bus.b_in[3*j +: 3];
                            gnt_d[j] = 1'b1;
                        end
                    end
                    ptr_d   = win;
                    cnt_d   = CW'(SETTLE - 1);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    res_d = sample;
                    err_d = !is_onehot3(sample);
                    for (int j = 0; j < NREQ; j++) begin
                        if (PW'(j) == ptr_q) done_d[j] = 1'b1;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any compare in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(NREQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            err_q   <= err_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.res     = res_q;
    assign bus.res_err = err_q;
    assign bus.cmp_X   = x_q;
    assign bus.cmp_Y   = y_q;
endmodule

// File: doc/cmp_share_arbiter.md
# cmp_share_arbiter

Round-robin arbiter and sequencer that shares one 3-bit magnitude comparator (`three_bit_cmpare`) among several requesters. It grants a requester, latches the requester's operand pair onto the comparator inputs, and waits a programmable number of settle cycles for the gate-level ripple logic to resolve. It then samples the comparator result, checks it for consistency, and returns it to the granted requester with a one-cycle done pulse. The comparator instance sits outside this block, and its ports connect directly to the `cmp_*` signals.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2–8.
- `SETTLE`, default 2: clock cycles the comparator inputs are held before the result is sampled; must be ≥ 1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input `NREQ`: request per requester. Level-sensitive; sampled only in IDLE.
- `a_in` input `3*NREQ`: operand X for requester i, at bits [3i+2:3i].
- `b_in` input `3*NREQ`: operand Y for requester i, at bits [3i+2:3i].
- `gnt` output `NREQ`: one-hot grant. Held from the first SETTLE cycle through the DONE cycle.
- `done` output `NREQ`: one-hot, one-cycle pulse. Marks the cycle in which `res` and `res_err` are valid for that requester.
- `res` output 3: registered result {gt, lt, eq}.
- `res_err` output 1: asserted with `done` when the sampled comparator outputs are not exactly one-hot.
- `cmp_X` output 3: registered operand X driven to the comparator.
- `cmp_Y` output 3: registered operand Y driven to the comparator.
- `cmp_xgty` input 1: comparator "greater than" output.
- `cmp_xlty` input 1: comparator "less than" output.
- `cmp_xeqy` input 1: comparator "equal" output.

## Operation
- **States:** IDLE, SETTLE, DONE.
- **IDLE:**
  - If `req` ≠ 0, select the winner by round-robin: search from `ptr+1` upward, wrapping modulo `NREQ`.
  - Register `cmp_X`/`cmp_Y` from the winner's operand slices and set `gnt` to the winner's bit.
  - Set `ptr` to the winner, load `cnt` with `SETTLE-1`, and go to SETTLE.
  - If `req` = 0, stay in IDLE with all outputs unchanged, except `done` = 0.
- **SETTLE:**
  - `cmp_X`/`cmp_Y` are held constant.
  - If `cnt` = 0: register `res` = {`cmp_xgty`, `cmp_xlty`, `cmp_xeqy`}, register `res_err` = (that vector is not one-hot), set `done[ptr]`, and go to DONE.
  - Otherwise decrement `cnt`.
- **DONE:** single cycle. `done` and `gnt` are deasserted on exit; go to IDLE.
- **Result hold:** `res` holds its value until the next sample, so it is readable after `done`.
- **Operand capture:** operands are captured at grant. Requester operand changes after that cycle have no effect on the compare in progress.
- **Request withdrawal:** a request dropped during SETTLE or DONE does not abort the compare; the done pulse still occurs.
- **Persistent requests:** a requester that holds `req` high after `done` is treated as a new request. Round-robin order guarantees that every other pending requester is served first.
- **Reset values:**
  - State = IDLE.
  - `gnt`, `done`, `res`, `res_err`, `cmp_X`, `cmp_Y` = 0.
  - `ptr` = `NREQ-1`, so requester 0 has first priority.
  - `cnt` = 0.
- **Reset mid-operation:** reset in any state aborts the compare. No `done` is issued for it.

## Timing
- **Grant:** `req` sampled in IDLE at edge k. `gnt`, `cmp_X`, and `cmp_Y` are valid after edge k.
- **Settle window:** the comparator sees stable inputs for exactly `SETTLE` cycles before sampling.
- **Result:** `done`, `res`, and `res_err` are valid after edge k+`SETTLE`. This is the DONE cycle.
- **Next grant:** the earliest next grant is after edge k+`SETTLE`+2.
- **Throughput:** one compare per `SETTLE`+2 cycles.
- **Clocking requirement:** `SETTLE` × clock period must exceed the comparator's worst-case path, which is the ripple carry chain followed by the 7-unit AND and the NOR.

## Test plan
- **Single requester:** `NREQ`=4, `SETTLE`=2, `req`=0001, X=5, Y=3 → `gnt`=0001 for 3 cycles; `done`=0001 two cycles after grant; `res`=100, `res_err`=0.
- **Equal and less-than:** X=6, Y=6 → `res`=001. X=2, Y=7 → `res`=010. Each result arrives `SETTLE` cycles after its grant.
- **Round-robin fairness:** `req`=1111 held continuously → grants in order 0,1,2,3,0. Requester 0 is not regranted until 1, 2 and 3 have each received a `done`.
- **Operand and request changes:** change `a_in` slice and drop `req` one cycle after grant → `res` reflects the captured operands; `done` still pulses.
- **Error path:** force `cmp_xgty`=`cmp_xeqy`=1 at sample → `res`=101 and `res_err`=1 with `done`. With `cmp_*`=000 → `res`=000 and `res_err`=1.
- **Reset mid-SETTLE:** assert `rst` during SETTLE → next cycle all outputs are 0, `ptr`=3, no `done`. A subsequent `req`=1000 is granted to requester 3.
